// File: rtl/dd_incoming_0.sv
// Incoming-ack stage 0: validates cumulative/selective acks against the flow window and
// produces the updated acked/retransmit bitmaps through a two-stage, hazard-aware pipeline.
`ifndef FLOW_ID_W
`define FLOW_ID_W 16
`endif
`ifndef PKT_TYPE_W
`define PKT_TYPE_W 8
`endif
`ifndef PKT_DATA_W
`define PKT_DATA_W 16
`endif
`ifndef FLOW_SEQ_NUM_W
`define FLOW_SEQ_NUM_W 32
`endif
`ifndef TX_CNT_W
`define TX_CNT_W 8
`endif
`ifndef TIME_W
`define TIME_W 32
`endif
`ifndef FLOW_WIN_SIZE
`define FLOW_WIN_SIZE 128
`endif
`ifndef FLOW_WIN_IND_W
`define FLOW_WIN_IND_W 8
`endif
`ifndef FLAG_W
`define FLAG_W 1
`endif

module dd_incoming_0 #(
  parameter bit ENABLE_SACK = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [`FLOW_ID_W-1:0]      flow_id_in,
  input  logic [`PKT_TYPE_W-1:0]     pkt_type_in,
  input  logic [`PKT_DATA_W-1:0]     pkt_data_in,
  input  logic [`FLOW_SEQ_NUM_W-1:0] cumulative_ack_in,
  input  logic [`FLOW_SEQ_NUM_W-1:0] selective_ack_in,
  input  logic [`TX_CNT_W-1:0]       sack_tx_id_in,
  input  logic [`TIME_W-1:0]         now,
  input  logic [`FLOW_WIN_SIZE-1:0]  acked_wnd_in,
  input  logic [`FLOW_WIN_SIZE-1:0]  rtx_wnd_in,
  input  logic [`FLOW_WIN_IND_W-1:0] wnd_start_ind_in,
  input  logic [`FLOW_SEQ_NUM_W-1:0] wnd_start_in,
  input  logic [`FLOW_SEQ_NUM_W-1:0] next_new_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [`FLOW_ID_W-1:0]      flow_id_out,
  output logic [`PKT_TYPE_W-1:0]     pkt_type_out,
  output logic [`PKT_DATA_W-1:0]     pkt_data_out,
  output logic [`FLOW_SEQ_NUM_W-1:0] cumulative_ack_out,
  output logic [`FLOW_SEQ_NUM_W-1:0] selective_ack_out,
  output logic [`TX_CNT_W-1:0]       sack_tx_id_out,
  output logic [`TIME_W-1:0]         now_out,
  output logic [`FLAG_W-1:0]         valid_selective_ack,
  output logic [`FLOW_WIN_IND_W-1:0] new_c_acks_cnt,
  output logic [`FLOW_SEQ_NUM_W-1:0] old_wnd_start_out,
  output logic [`FLOW_WIN_SIZE-1:0]  acked_wnd_out,
  output logic [`FLOW_WIN_SIZE-1:0]  rtx_wnd_out,
  output logic [`FLOW_WIN_IND_W-1:0] wnd_start_ind_out,
  output logic [`FLOW_SEQ_NUM_W-1:0] wnd_start_out
);

  localparam int unsigned WinSize = `FLOW_WIN_SIZE;
  localparam int unsigned IdxW    = $clog2(WinSize);
  localparam int unsigned IndW    = `FLOW_WIN_IND_W;
  localparam int unsigned SeqW    = `FLOW_SEQ_NUM_W;
  localparam int unsigned FlagW   = `FLAG_W;

  // Stage 1 state
  logic                       s1_valid_q;
  logic [`FLOW_ID_W-1:0]      s1_flow_q;
  logic [`PKT_TYPE_W-1:0]     s1_pkt_type_q;
  logic [`PKT_DATA_W-1:0]     s1_pkt_data_q;
  logic [SeqW-1:0]            s1_cack_q;
  logic [SeqW-1:0]            s1_sack_q;
  logic [`TX_CNT_W-1:0]       s1_tx_id_q;
  logic [`TIME_W-1:0]         s1_now_q;
  logic [WinSize-1:0]         s1_acked_q;
  logic [WinSize-1:0]         s1_rtx_q;
  logic [IndW-1:0]            s1_ind_q;
  logic [SeqW-1:0]            s1_ws_q;
  logic [SeqW-1:0]            s1_nn_q;
  logic                       s1_cack_ok_q;
  logic [IndW-1:0]            s1_cnt_q;

  logic                       s2_valid_q;

  logic                       s1_adv;
  logic                       hazard;
  logic                       cack_ok;
  logic [SeqW-1:0]            cack_diff;
  logic [IndW-1:0]            cnt;

  logic [SeqW-1:0]            wso;
  logic [IdxW-1:0]            ind_low;
  logic [SeqW-1:0]            sack_off;
  logic                       sack_ok;
  logic [IdxW-1:0]            sack_idx;
  logic [IdxW-1:0]            slot_off;
  logic [WinSize-1:0]         clr_mask;
  logic [WinSize-1:0]         acked_nxt;
  logic [WinSize-1:0]         rtx_nxt;

  assign out_valid = s2_valid_q;
  assign s1_adv    = s1_valid_q && (!s2_valid_q || out_ready);
  // Same-flow events must not overlap, otherwise the second would see stale window context.
  assign hazard    = (s1_valid_q && (s1_flow_q == flow_id_in)) ||
                     (s2_valid_q && (flow_id_out == flow_id_in));
  assign in_ready  = (!s1_valid_q || s1_adv) && !hazard;

  always_comb begin
    cack_ok   = (wnd_start_in < cumulative_ack_in) && (cumulative_ack_in <= next_new_in);
    cack_diff = cumulative_ack_in - wnd_start_in;
    cnt       = '0;
    if (cack_ok) begin
      cnt = (cack_diff >= SeqW'(WinSize)) ? IndW'(WinSize) : IndW'(cack_diff);
    end
  end

  always_comb begin
    wso      = s1_cack_ok_q ? s1_cack_q : s1_ws_q;
    ind_low  = IdxW'(s1_ind_q + s1_cnt_q);
    sack_off = s1_sack_q - wso;
    sack_ok  = ENABLE_SACK && (wso <= s1_sack_q) && (s1_sack_q < s1_nn_q) &&
               (sack_off < SeqW'(WinSize));
    sack_idx = IdxW'(sack_off) + ind_low;
    slot_off = '0;
    clr_mask = '0;
    // A slot is freed when its distance from the old window start is below the ack count.
    for (int i = 0; i < int'(WinSize); i++) begin
      slot_off    = IdxW'(IndW'(i) - s1_ind_q);
      clr_mask[i] = IndW'(slot_off) < s1_cnt_q;
    end
    acked_nxt = s1_acked_q & ~clr_mask;
    rtx_nxt   = s1_rtx_q & ~clr_mask;
    if (sack_ok) begin
      acked_nxt[sack_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_flow_q     <= '0;
      s1_pkt_type_q <= '0;
      s1_pkt_data_q <= '0;
      s1_cack_q     <= '0;
      s1_sack_q     <= '0;
      s1_tx_id_q    <= '0;
      s1_now_q      <= '0;
      s1_acked_q    <= '0;
      s1_rtx_q      <= '0;
      s1_ind_q      <= '0;
      s1_ws_q       <= '0;
      s1_nn_q       <= '0;
      s1_cack_ok_q  <= 1'b0;
      s1_cnt_q      <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid_q    <= 1'b1;
      s1_flow_q     <= flow_id_in;
      s1_pkt_type_q <= pkt_type_in;
      s1_pkt_data_q <= pkt_data_in;
      s1_cack_q     <= cumulative_ack_in;
      s1_sack_q     <= selective_ack_in;
      s1_tx_id_q    <= sack_tx_id_in;
      s1_now_q      <= now;
      s1_acked_q    <= acked_wnd_in;
      s1_rtx_q      <= rtx_wnd_in;
      s1_ind_q      <= wnd_start_ind_in;
      s1_ws_q       <= wnd_start_in;
      s1_nn_q       <= next_new_in;
      s1_cack_ok_q  <= cack_ok;
      s1_cnt_q      <= cnt;
    end else if (s1_adv) begin
      s1_valid_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q          <= 1'b0;
      flow_id_out         <= '0;
      pkt_type_out        <= '0;
      pkt_data_out        <= '0;
      cumulative_ack_out  <= '0;
      selective_ack_out   <= '0;
      sack_tx_id_out      <= '0;
      now_out             <= '0;
      valid_selective_ack <= '0;
      new_c_acks_cnt      <= '0;
      old_wnd_start_out   <= '0;
      acked_wnd_out       <= '0;
      rtx_wnd_out         <= '0;
      wnd_start_ind_out   <= '0;
      wnd_start_out       <= '0;
    end else if (s1_adv) begin
      s2_valid_q          <= 1'b1;
      flow_id_out         <= s1_flow_q;
      pkt_type_out        <= s1_pkt_type_q;
      pkt_data_out        <= s1_pkt_data_q;
      cumulative_ack_out  <= s1_cack_q;
      selective_ack_out   <= s1_sack_q;
      sack_tx_id_out      <= s1_tx_id_q;
      now_out             <= s1_now_q;
      valid_selective_ack <= FlagW'(sack_ok);
      new_c_acks_cnt      <= s1_cnt_q;
      old_wnd_start_out   <= s1_ws_q;
      acked_wnd_out       <= acked_nxt;
      rtx_wnd_out         <= rtx_nxt;
      wnd_start_ind_out   <= {{(IndW - IdxW){1'b0}}, ind_low};
      wnd_start_out       <= wso;
    end else if (out_ready) begin
      s2_valid_q          <= 1'b0;
    end
  end

endmodule

// File: doc/dd_incoming_0.md
DD_INCOMING_0 -- requirements
Module: dd_incoming_0

Interface
REQ-001 SHALL have parameter ENABLE_SACK, default 1, meaning 1 processes selective acks and 0 ignores them.
REQ-002 SHALL have one clock and an asynchronous active-low reset: ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  event handshake; transfer occurs when both are high.
REQ-006 flow_id_in  input  `FLOW_ID_W  flow of the event.
REQ-007 pkt_type_in, pkt_data_in, cumulative_ack_in, selective_ack_in, sack_tx_id_in, now  inputs  `PKT_TYPE_W, `PKT_DATA_W, `FLOW_SEQ_NUM_W, `FLOW_SEQ_NUM_W, `TX_CNT_W, `TIME_W  event fields.
REQ-008 acked_wnd_in, rtx_wnd_in, wnd_start_ind_in, wnd_start_in, next_new_in  inputs  `FLOW_WIN_SIZE, `FLOW_WIN_SIZE, `FLOW_WIN_IND_W, `FLOW_SEQ_NUM_W, `FLOW_SEQ_NUM_W  flow context sampled with the event.
REQ-009 out_valid / out_ready  output / input  1 / 1  result handshake to dd_incoming_1.
REQ-010 Outputs: flow_id_out, all event fields (passthrough), valid_selective_ack (`FLAG_W), new_c_acks_cnt (`FLOW_WIN_IND_W), old_wnd_start_out, acked_wnd_out, rtx_wnd_out, wnd_start_ind_out, wnd_start_out.

Function
REQ-011 SHALL be a two-stage pipeline: S1 registers the event, context and compare results; S2 registers the window update and drives the outputs.
REQ-012 Latency SHALL be exactly 2 cycles from the input transfer to out_valid when there is no backpressure.
REQ-013 Throughput SHALL be one event per cycle with no hazard and no stall.
REQ-014 When out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-015 S1 SHALL advance only if S2 is empty or S2 is being drained in the same cycle; in_ready SHALL equal S1 empty or S1 advancing.
REQ-016 Hazard: in_ready SHALL be 0 while S1 or S2 holds a valid event with the same flow_id_in; the stall SHALL release in the cycle after that event leaves S2.
REQ-017 Cumulative ack SHALL be valid iff wnd_start_in < cumulative_ack_in <= next_new_in (unsigned).
REQ-018 new_c_acks_cnt SHALL be cumulative_ack_in - wnd_start_in when the cumulative ack is valid, else 0; the difference SHALL saturate at `FLOW_WIN_SIZE.
REQ-019 wnd_start_out SHALL be cumulative_ack_in when the cumulative ack is valid, else wnd_start_in; old_wnd_start_out SHALL equal wnd_start_in.
REQ-020 wnd_start_ind_out SHALL be {1'b0, (wnd_start_ind_in + new_c_acks_cnt) mod `FLOW_WIN_SIZE}, with the MSB always 0.
REQ-021 valid_selective_ack SHALL be 1 iff all of the following hold: ENABLE_SACK=1, wnd_start_out <= selective_ack_in < next_new_in, and selective_ack_in - wnd_start_out < `FLOW_WIN_SIZE.
REQ-022 The freed slots, indices wnd_start_ind_in .. wnd_start_ind_in+cnt-1 mod `FLOW_WIN_SIZE (wrap-around allowed), SHALL be cleared in both acked_wnd_out and rtx_wnd_out.
REQ-023 When cnt=`FLOW_WIN_SIZE, every bit SHALL be cleared.
REQ-024 If valid_selective_ack=1, bit (selective_ack_in - wnd_start_out + wnd_start_ind_out) mod `FLOW_WIN_SIZE of acked_wnd_out SHALL be set after the clears are applied.
REQ-025 All other bits of acked_wnd_out and rtx_wnd_out SHALL pass through unchanged.
REQ-026 A cumulative ack equal to wnd_start_in (duplicate) SHALL give cnt=0 and leave the window unchanged.

Reset
REQ-027 On rst_n=0, SHALL asynchronously clear the S1/S2 valid flags, so out_valid=0 and in_ready=1 one cycle after deassert.
REQ-028 All data outputs SHALL reset to 0.
REQ-029 Reset mid-operation SHALL drop in-flight events with no partial output.

Verification
REQ-030 FLOW_WIN_SIZE=128, wnd_start=100, ind=120, next_new=140, cack=110, sack=0 -> after 2 cycles: cnt=10, wnd_start_out=110, ind_out=2, acked bits 120..127 and 0..1 cleared.
REQ-031 cack=100 (duplicate), sack=105 -> cnt=0, valid_selective_ack=1, acked bit (105-100+120)=125 set, wnd_start_out=100.
REQ-032 sack=140 (= next_new) -> valid_selective_ack=0 and acked_wnd_out equals acked_wnd_in with only the freed slots cleared.
REQ-033 Back-to-back events for flows 3,3 -> second event's in_ready=0 until the first event leaves S2; the second event's output follows 2 cycles after its own transfer.
REQ-034 Events A,B,C on distinct flows with out_ready=0 for 5 cycles -> outputs hold A, in_ready falls after 2 accepts, and order A,B,C is preserved with no loss after release.
REQ-035 rst_n pulsed low while 2 events are in flight -> out_valid=0 immediately and no output appears after release.
